// File: rtl/midi_pkg.sv
// Shared types for the MIDI message parser: FSM states, status classes, message record.
// Also holds the data-length lookup used to classify channel status bytes.
package midi_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_D1 = 2'd1,
      WAIT_D2 = 2'd2,
      SYSEX   = 2'd3
   } state_t;

   localparam logic [3:0] NOTE_OFF    = 4'h8;
   localparam logic [3:0] NOTE_ON     = 4'h9;
   localparam logic [3:0] POLY_AT     = 4'hA;
   localparam logic [3:0] CC          = 4'hB;
   localparam logic [3:0] PROG        = 4'hC;
   localparam logic [3:0] CH_AT       = 4'hD;
   localparam logic [3:0] PITCH       = 4'hE;
   localparam logic [7:0] SYSEX_START = 8'hF0;
   localparam logic [7:0] RT_MIN      = 8'hF8;

   typedef struct packed {
      logic [7:0] status;
      logic [6:0] data1;
      logic [6:0] data2;
      logic [1:0] len;
   } msg_t;

   function automatic logic [1:0] data_len(input logic [7:0] status);
      case (status[7:4])
         NOTE_OFF, NOTE_ON, POLY_AT, CC, PITCH: data_len = 2'd2;
         PROG, CH_AT:                           data_len = 2'd1;
         default:                               data_len = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/midi_msg_parser_if.sv
// Message bus from the parser to the voice allocator; master drives the message, slave drives ready.
// Fields are held stable while msg_valid is high and msg_ready is low.
interface midi_msg_parser_if;
   logic [7:0] msg_status;
   logic [6:0] msg_data1;
   logic [6:0] msg_data2;
   logic [1:0] msg_len;
   logic       msg_valid;
   logic       msg_ready;

   modport master (
      output msg_status, msg_data1, msg_data2, msg_len, msg_valid,
      input  msg_ready
   );

   modport slave (
      input  msg_status, msg_data1, msg_data2, msg_len, msg_valid,
      output msg_ready
   );
endinterface

// File: rtl/midi_msg_outreg.sv
// One-entry valid/ready output register; a load becomes visible the next cycle.
// Loads while full and not being accepted are dropped and set the sticky overrun flag.
module midi_msg_outreg
   import midi_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      load,
   input  msg_t                      load_msg,
   input  logic                      overrun_clr,
   output logic                      overrun,
   midi_msg_parser_if.master         msg
);

   msg_t held_q;
   logic vld_q;
   logic ovr_q;
   logic accept;
   logic take;
   logic drop;

   assign accept = vld_q & msg.msg_ready;
   // A handshake this cycle frees the slot, so a same-cycle load is still taken.
   assign take   = load & (~vld_q | accept);
   assign drop   = load & vld_q & ~accept;

   always_ff @(posedge clk) begin
      if (rst) begin
         held_q <= '0;
         vld_q  <= 1'b0;
         ovr_q  <= 1'b0;
      end else begin
         if (take) begin
            held_q <= load_msg;
            vld_q  <= 1'b1;
         end else if (accept) begin
            vld_q  <= 1'b0;
         end
         if (drop) begin
            ovr_q <= 1'b1;
         end else if (overrun_clr) begin
            ovr_q <= 1'b0;
         end
      end
   end

   assign msg.msg_status = held_q.status;
   assign msg.msg_data1  = held_q.data1;
   assign msg.msg_data2  = held_q.data2;
   assign msg.msg_len    = held_q.len;
   assign msg.msg_valid  = vld_q;
   assign overrun        = ovr_q;

endmodule

// File: rtl/midi_msg_parser.sv
// MIDI channel-voice message assembler with running status and real-time pass-through; 1-cycle latency.
// Output stalls hold the current message; completions while full are dropped (overrun). MIDI_VEL0_NOTE_OFF_EN maps velocity-0 note-on to note-off.
module midi_msg_parser
   import midi_pkg::*;
#(
   parameter bit         C_OMNI    = 1'b1,
   parameter logic [3:0] C_CHANNEL = 4'd0,
   parameter bit         C_RT_PASS = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [7:0]                byte_in,
   input  logic                      byte_valid,
   midi_msg_parser_if.master         msg,
   output logic                      overrun,
   input  logic                      overrun_clr
);

   state_t     state_q, state_d;
   logic [7:0] run_stat_q, run_stat_d;
   logic       run_vld_q, run_vld_d;
   logic [6:0] data1_q, data1_d;

   logic       done;
   msg_t       done_msg;
   logic       chan_ok;
   logic       emit;
   msg_t       emit_msg;

   assign chan_ok = C_OMNI || (run_stat_q[3:0] == C_CHANNEL);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         run_stat_q <= 8'h00;
         run_vld_q  <= 1'b0;
         data1_q    <= '0;
      end else begin
         state_q    <= state_d;
         run_stat_q <= run_stat_d;
         run_vld_q  <= run_vld_d;
         data1_q    <= data1_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      run_stat_d = run_stat_q;
      run_vld_d  = run_vld_q;
      data1_d    = data1_q;
      done       = 1'b0;
      done_msg   = '0;
      emit       = 1'b0;
      emit_msg   = '0;

      if (byte_valid) begin
         if (byte_in >= RT_MIN) begin
            // Real-time bytes leave all parse state untouched and bypass the channel filter.
            if (C_RT_PASS) begin
               emit            = 1'b1;
               emit_msg.status = byte_in;
            end
         end else if (byte_in >= 8'h80 && byte_in < SYSEX_START) begin
            run_stat_d = byte_in;
            run_vld_d  = 1'b1;
            state_d    = WAIT_D1;
         end else if (byte_in == SYSEX_START) begin
            run_vld_d = 1'b0;
            state_d   = SYSEX;
         end else if (byte_in[7]) begin
            run_vld_d = 1'b0;
            state_d   = IDLE;
         end else begin
            case (state_q)
               IDLE, WAIT_D1: begin
                  if (state_q == WAIT_D1 || run_vld_q) begin
                     if (data_len(run_stat_q) == 2'd1) begin
                        done           = 1'b1;
                        done_msg.status = run_stat_q;
                        done_msg.data1  = byte_in[6:0];
                        done_msg.len    = 2'd1;
                        state_d         = IDLE;
                     end else begin
                        data1_d = byte_in[6:0];
                        state_d = WAIT_D2;
                     end
                  end
               end
               WAIT_D2: begin
                  done            = 1'b1;
                  done_msg.status = run_stat_q;
                  done_msg.data1  = data1_q;
                  done_msg.data2  = byte_in[6:0];
                  done_msg.len    = 2'd2;
                  state_d         = IDLE;
               end
               default: ;
            endcase
         end
      end

      if (done && chan_ok) begin
         emit     = 1'b1;
         emit_msg = done_msg;
`ifdef MIDI_VEL0_NOTE_OFF_EN
         // Only the emitted copy is rewritten; run_stat keeps the note-on class.
         if (done_msg.status[7:4] == NOTE_ON && done_msg.data2 == 7'd0) begin
            emit_msg.status = {NOTE_OFF, done_msg.status[3:0]};
            emit_msg.data2  = 7'h40;
         end
`endif
      end
   end

   midi_msg_outreg u_outreg (
      .clk         (clk),
      .rst         (rst),
      .load        (emit),
      .load_msg    (emit_msg),
      .overrun_clr (overrun_clr),
      .overrun     (overrun),
      .msg         (msg)
   );

endmodule

// File: doc/midi_msg_parser.md
Name: midi_msg_parser

Overview:
- Downstream stage of the MIDI UART receiver.
- Consumes the received byte stream (one-cycle byte strobe per byte) and assembles complete MIDI channel-voice messages: status, data1, data2.
- Handles running status and interleaved real-time bytes.
- Presents each complete message on a valid/ready output toward the synth voice allocator, with a one-entry output register.

Parameters:
- C_OMNI, default 1: 1 accepts all channels; 0 accepts only C_CHANNEL.
- C_CHANNEL, default 0: 4-bit MIDI channel accepted when C_OMNI=0.
- C_RT_PASS, default 1: 1 forwards real-time bytes (0xF8-0xFF) as single-byte messages; 0 discards them.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- byte_in  in  8  received MIDI byte
- byte_valid  in  1  single-cycle strobe; byte_in is valid this cycle
- msg_status  out  8  status byte of the message
- msg_data1  out  7  first data byte; 0 if the message has none
- msg_data2  out  7  second data byte; 0 if the message has none
- msg_len  out  2  number of data bytes: 0, 1 or 2
- msg_valid  out  1  message held in the output register
- msg_ready  in  1  consumer accepts the message when msg_valid & msg_ready
- overrun  out  1  sticky: a completed message was dropped
- overrun_clr  in  1  clears overrun

Behaviour:
- Reset: all outputs 0; running status cleared (run_stat=0x00, run_vld=0); FSM in IDLE; output register empty.
- Length class of a status byte:
  - 2 data bytes: 0x8n, 0x9n, 0xAn, 0xBn, 0xEn.
  - 1 data byte: 0xCn, 0xDn.
- FSM states: IDLE, WAIT_D1, WAIT_D2, SYSEX. Transitions occur only on cycles with byte_valid=1.
- Real-time byte (>=0xF8), any state:
  - No state change; running status and partial data are preserved.
  - If C_RT_PASS=1, emit msg_status=byte, msg_len=0, data fields 0.
- Channel status (0x80-0xEF), any state:
  - Load run_stat, set run_vld; abandon any partial message (it is not emitted).
  - Go to WAIT_D1.
- 0xF0: clear run_vld; go to SYSEX.
- 0xF1-0xF7: clear run_vld; go to IDLE.
- Data byte (<0x80), by state:
  - IDLE, run_vld=1: treated as data1 (running status).
  - IDLE, run_vld=0: discarded.
  - WAIT_D1: latch data1. For a 1-data class, emit the message and go to IDLE. Otherwise go to WAIT_D2.
  - WAIT_D2: latch data2, emit the message, go to IDLE.
  - SYSEX: discarded.
- Running-status path from IDLE:
  - 2-data class: latch data1, go to WAIT_D2.
  - 1-data class: emit immediately.
- Channel filter:
  - When C_OMNI=0 and run_stat[3:0] != C_CHANNEL, messages are parsed but not emitted.
  - Real-time messages are never filtered.
- Emit: the output register loads on the clock edge that samples the final byte, so msg_valid is high the following cycle (latency 1 cycle from the final byte_valid).
- Output handshake:
  - msg_valid stays high, with fields stable, until msg_valid & msg_ready.
  - An emit on the same cycle as the accepting handshake loads the new message, and msg_valid stays high (back-to-back throughput).
  - An emit while the register is full and not being accepted: the new message is dropped, the held message is kept, and overrun is set.
- overrun clearing:
  - overrun_clr clears overrun.
  - If a set event occurs in the same cycle as overrun_clr, the set wins.
- Reset mid-message: partial data and running status are lost; no emit.

Optional Feature:
- Macro: MIDI_VEL0_NOTE_OFF_EN.
- Defined: a completed 0x9n message with data2=0 is emitted with msg_status=0x8n and data2=0x40. run_stat is unchanged, so subsequent running-status bytes still decode as 0x9n.
- Undefined: 0x9n messages with velocity 0 pass unchanged.

Decomposition:
- Shared package midi_pkg holds:
  - FSM state encoding.
  - Status-class constants: NOTE_OFF=0x8, NOTE_ON=0x9, POLY_AT=0xA, CC=0xB, PROG=0xC, CH_AT=0xD, PITCH=0xE, SYSEX_START=0xF0, RT_MIN=0xF8.
  - Data-length lookup function.
- Natural sub-module: midi_msg_outreg, the one-entry valid/ready output register with drop/overrun logic. The FSM stays in the parent.

Test Plan:
- Bytes 0x90,0x3C,0x64 with msg_ready=1: one msg_valid pulse with status 0x90, data1 0x3C, data2 0x64, len 2, high 1 cycle after the third strobe.
- Bytes 0x90,0x3C,0x64,0x40,0x00:
  - Two messages: (0x90,0x3C,0x64), then (0x90,0x40,0x00).
  - With MIDI_VEL0_NOTE_OFF_EN defined, the second is (0x80,0x40,0x40).
- Bytes 0xB0,0xF8,0x07,0x7F:
  - Real-time message 0xF8 (len 0) first, then (0xB0,0x07,0x7F); the real-time byte does not corrupt the CC.
  - With C_RT_PASS=0, only the CC is emitted.
- Bytes 0xC5,0x0A,0x0B: two 1-data messages (0xC5,0x0A) and (0xC5,0x0B), both with len 1 and data2=0.
- Bytes 0xF0,0x7E,0x01,0xF7,0x20: no message emitted; the trailing 0x20 is discarded because run_vld=0.
- Output stall:
  - Stimulus: hold msg_ready=0, send two complete 0x80 messages.
  - Required: the first is held stable; overrun asserts 1 cycle after the second completes.
  - Then msg_ready=1 accepts the first; overrun_clr clears overrun.
  - Also: rst mid-message (after 0x90,0x3C) returns all outputs to 0 and a following 0x64 is discarded.
